// File: rtl/butterfly16_unloader.sv
// Ping-pong frame unloader: accepts 16-sample complex frames in one beat and
// streams them out one sample per cycle, optionally in bit-reversed index order.
module butterfly16_unloader #(
  parameter int BIT_REVERSE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [543:0] frame_in,
  input  logic         frame_valid,
  output logic         frame_ready,
  output logic [33:0]  sample_out,
  output logic [3:0]   sample_idx,
  output logic         sample_valid,
  input  logic         sample_ready,
  output logic         sample_last,
  output logic         busy
);

  logic [543:0] frame_mem [0:1];
  logic [33:0]  samples [0:15];

  logic       wp_reg;
  logic       rp_reg;
  logic [1:0] cnt_reg;
  logic [1:0] cnt_next;
  logic [3:0] pos_reg;

  logic accept;
  logic xfer;
  logic last_xfer;

  // Handshake outputs depend on registered occupancy only.
  assign frame_ready  = (cnt_reg != 2'd2);
  assign sample_valid = (cnt_reg != 2'd0);
  assign busy         = (cnt_reg != 2'd0);
  assign sample_last  = sample_valid && (pos_reg == 4'd15);

  assign accept    = frame_valid && frame_ready;
  assign xfer      = sample_valid && sample_ready;
  assign last_xfer = xfer && (pos_reg == 4'd15);

  always_comb begin
    cnt_next = cnt_reg;
    if (accept && !last_xfer) begin
      cnt_next = cnt_reg + 2'd1;
    end else if (!accept && last_xfer) begin
      cnt_next = cnt_reg - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= 2'd0;
      pos_reg <= 4'd0;
      wp_reg  <= 1'b0;
      rp_reg  <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      if (accept) begin
        wp_reg <= ~wp_reg;
      end
      if (xfer) begin
        pos_reg <= pos_reg + 4'd1;
      end
      if (last_xfer) begin
        rp_reg <= ~rp_reg;
      end
    end
  end

  // Frame storage carries no reset; wp never equals rp while a frame is being read
  // and a write is possible, so the buffer being streamed is never overwritten.
  always_ff @(posedge clk) begin
    if (accept) begin
      frame_mem[wp_reg] <= frame_in;
    end
  end

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_sample
      assign samples[gi] = frame_mem[rp_reg][34*gi +: 34];
    end

    if (BIT_REVERSE != 0) begin : g_rev
      for (genvar gi = 0; gi < 4; gi++) begin : g_bit
        assign sample_idx[gi] = pos_reg[3-gi];
      end
    end else begin : g_nat
      assign sample_idx = pos_reg;
    end
  endgenerate

  assign sample_out = samples[sample_idx];

endmodule
